// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the full-speed USB packet transmitter.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        PKT_DATA0 = 3'd1,
        PKT_DATA1 = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_STALL = 3'd5
    } tx_pkt_e;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC, ST_EOP
    } tx_state_e;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    function automatic logic pkt_valid(input logic [2:0] p);
        return (p != 3'd0) && (p <= 3'd5);
    endfunction

    function automatic logic pkt_is_data(input logic [2:0] p);
        return (p == PKT_DATA0) || (p == PKT_DATA1);
    endfunction

    function automatic logic [3:0] pid_of(input logic [2:0] p);
        case (p)
            PKT_DATA0: return PID_DATA0;
            PKT_DATA1: return PID_DATA1;
            PKT_ACK:   return PID_ACK;
            PKT_NAK:   return PID_NAK;
            default:   return PID_STALL;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial USB CRC16, LSB-first data; register shifts right with the reflected polynomial.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    localparam logic [15:0] POLY_REFL = reflect16(CRC16_POLY);

    logic [15:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst)        crc_q <= '0;
        else if (clr_i) crc_q <= CRC16_INIT;
        else if (en_i)  crc_q <= (crc_q >> 1) ^ ((bit_i ^ crc_q[0]) ? POLY_REFL : 16'h0000);
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/usb_tx_packet.sv
// Full-speed USB packet transmitter: SYNC/PID/payload/CRC16/EOP with bit stuffing and NRZI.
module usb_tx_packet
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       dp_out,
    output logic       dm_out,
    output logic       tx_transfer_active,
    output logic       tx_error
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]    MAX_B    = 7'(MAX_PAYLOAD);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] clk_cnt_q;
    logic [3:0]    idx_q, idx_d;
    logic [2:0]    ones_q, ones_d;
    logic [6:0]    rem_q;
    logic [7:0]    shift_q;
    logic [2:0]    pkt_q;
    logic          nrzi_q, nrzi_d;
    logic          stuff_d, load_d, bit_d;
    logic          dp_q, dm_q, get_q, act_q, err_q;
    logic          accept, boundary;
    logic [3:0]    pid;
    logic [7:0]    pid_byte;
    logic [15:0]   crc;

    assign accept   = (state_q == ST_IDLE) && tx_start && pkt_valid(tx_packet);
    assign boundary = (state_q != ST_IDLE) && (clk_cnt_q == CNT_LAST);
    assign pid      = pid_of(pkt_q);
    assign pid_byte = {~pid, pid};

    // Decide the bit for the next bit time; evaluated every cycle, committed on a boundary.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q + 4'd1;
        stuff_d = 1'b0;
        load_d  = 1'b0;
        bit_d   = 1'b1;
        if (state_q != ST_IDLE && state_q != ST_EOP && ones_q == 3'd6) begin
            stuff_d = 1'b1;
            idx_d   = idx_q;
        end else begin
            case (state_q)
                ST_SYNC: if (idx_q == 4'd7) begin
                    state_d = ST_PID;
                    idx_d   = 4'd0;
                end
                ST_PID: if (idx_q == 4'd7) begin
                    idx_d = 4'd0;
                    if (!pkt_is_data(pkt_q)) state_d = ST_EOP;
                    else if (rem_q != 7'd0) begin
                        state_d = ST_DATA;
                        load_d  = 1'b1;
                    end else state_d = ST_CRC;
                end
                ST_DATA: if (idx_q == 4'd7) begin
                    idx_d = 4'd0;
                    if (rem_q != 7'd0) load_d = 1'b1;
                    else state_d = ST_CRC;
                end
                ST_CRC: if (idx_q == 4'd15) begin
                    state_d = ST_EOP;
                    idx_d   = 4'd0;
                end
                ST_EOP: if (idx_q == 4'd2) begin
                    state_d = ST_IDLE;
                    idx_d   = 4'd0;
                end
                default: idx_d = idx_q;
            endcase
        end
        case (state_d)
            ST_SYNC: bit_d = SYNC_BYTE[idx_d[2:0]];
            ST_PID:  bit_d = pid_byte[idx_d[2:0]];
            ST_DATA: bit_d = load_d ? tx_packet_data[idx_d[2:0]] : shift_q[idx_d[2:0]];
            ST_CRC:  bit_d = ~crc[idx_d];
            default: bit_d = 1'b1;
        endcase
        if (stuff_d) bit_d = 1'b0;
        if (stuff_d || !bit_d || state_d == ST_EOP || state_d == ST_IDLE) ones_d = 3'd0;
        else ones_d = ones_q + 3'd1;
        nrzi_d = bit_d ? nrzi_q : ~nrzi_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            idx_q     <= '0;
            ones_q    <= '0;
            rem_q     <= '0;
            shift_q   <= '0;
            pkt_q     <= '0;
            nrzi_q    <= 1'b1;
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
            get_q     <= 1'b0;
            act_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            get_q <= 1'b0;
            err_q <= (state_q == ST_IDLE) && tx_start && !pkt_valid(tx_packet);
            if (accept) begin
                // First SYNC bit is NRZI-encoded from J straight away.
                state_q   <= ST_SYNC;
                clk_cnt_q <= '0;
                idx_q     <= '0;
                ones_q    <= {2'b00, SYNC_BYTE[0]};
                rem_q     <= (buffer_occupancy > MAX_B) ? MAX_B : buffer_occupancy;
                pkt_q     <= tx_packet;
                nrzi_q    <= SYNC_BYTE[0];
                dp_q      <= SYNC_BYTE[0];
                dm_q      <= ~SYNC_BYTE[0];
                act_q     <= 1'b1;
            end else if (state_q != ST_IDLE) begin
                clk_cnt_q <= boundary ? '0 : clk_cnt_q + CW'(1);
                if (boundary) begin
                    state_q <= state_d;
                    idx_q   <= idx_d;
                    ones_q  <= ones_d;
                    if (load_d) begin
                        shift_q <= tx_packet_data;
                        rem_q   <= rem_q - 7'd1;
                        get_q   <= 1'b1;
                    end
                    if (state_d == ST_EOP) begin
                        dp_q <= (idx_d == 4'd2);
                        dm_q <= 1'b0;
                    end else if (state_d == ST_IDLE) begin
                        nrzi_q <= 1'b1;
                        dp_q   <= 1'b1;
                        dm_q   <= 1'b0;
                        act_q  <= 1'b0;
                    end else begin
                        nrzi_q <= nrzi_d;
                        dp_q   <= nrzi_d;
                        dm_q   <= ~nrzi_d;
                    end
                end
            end
        end
    end

    usb_crc16 u_crc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (boundary && state_d == ST_DATA && !stuff_d),
        .bit_i (bit_d),
        .crc_o (crc)
    );

    assign get_tx_packet_data = get_q;
    assign dp_out             = dp_q;
    assign dm_out             = dm_q;
    assign tx_transfer_active = act_q;
    assign tx_error           = err_q;

endmodule
